id_ex_register: RTL and testbench

ID_EX_REGISTER -- requirements
Module: id_ex_register

---
 rtl/id_ex_register.sv | 127 ++++++++++++
 tb/tb_id_ex_register.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a saturating stall counter.
// Latency: 1 cycle from id_* inputs to ex_* outputs. The stall output is combinational in the same cycle.
// Backpressure: stall asks upstream to hold the PC and IF/ID. This stage then inserts one bubble, and flush forces a bubble.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   id_* (controls)       - decode-stage control bits and id_ALUOp[1:0]
//   id_valid              - the decode slot holds a real instruction
//   id_pc_plus4/rdata1/2/imm, id_rs/rt/rd - decode-stage datapath and register numbers
//   flush                 - squash the decode slot (taken branch resolved downstream)
//   ex_* outputs          - registered copies presented to the execute stage
//   stall                 - load-use hazard between the load in EX and the consumer in ID
//   stall_count           - saturating count of cycles with stall high
module id_ex_register (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_RegDst,
    input  logic        id_ALUSrc,
    input  logic        id_Branch,
    input  logic        id_MemRead,
    input  logic        id_MemWrite,
    input  logic        id_RegWrite,
    input  logic        id_MemtoReg,
    input  logic [1:0]  id_ALUOp,
    input  logic        id_valid,
    input  logic [31:0] id_pc_plus4,
    input  logic [31:0] id_rdata1,
    input  logic [31:0] id_rdata2,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        flush,
    output logic        ex_RegDst,
    output logic [1:0]  ex_ALUOp,
    output logic        ex_ALUSrc,
    output logic        ex_Branch,
    output logic        ex_MemRead,
    output logic        ex_MemWrite,
    output logic        ex_RegWrite,
    output logic        ex_MemtoReg,
    output logic        ex_valid,
    output logic [31:0] ex_pc_plus4,
    output logic [31:0] ex_rdata1,
    output logic [31:0] ex_rdata2,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic        stall,
    output logic [15:0] stall_count
);

    logic insertBubble;
    logic countSaturated;

    // A load in EX whose destination feeds the instruction in ID must wait one cycle.
    // Register 0 is never a real dependency.
    assign stall = ex_valid & ex_MemRead & id_valid & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (ex_rt == id_rt));

    assign insertBubble   = flush | stall;
    assign countSaturated = (stall_count == 16'hFFFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_RegDst   <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_ALUSrc   <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_valid    <= 1'b0;
            ex_pc_plus4 <= 32'd0;
            ex_rdata1   <= 32'd0;
            ex_rdata2   <= 32'd0;
            ex_imm      <= 32'd0;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_rd       <= 5'd0;
            stall_count <= 16'd0;
        end else begin
            // The datapath always follows ID. A bubble is defined purely by its
            // cleared controls and valid bit.
            ex_pc_plus4 <= id_pc_plus4;
            ex_rdata1   <= id_rdata1;
            ex_rdata2   <= id_rdata2;
            ex_imm      <= id_imm;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;

            if (insertBubble) begin
                // Clearing ex_MemRead here also drops stall on the next cycle.
                ex_RegDst   <= 1'b0;
                ex_ALUOp    <= 2'b00;
                ex_ALUSrc   <= 1'b0;
                ex_Branch   <= 1'b0;
                ex_MemRead  <= 1'b0;
                ex_MemWrite <= 1'b0;
                ex_RegWrite <= 1'b0;
                ex_MemtoReg <= 1'b0;
                ex_valid    <= 1'b0;
            end else begin
                // RegDst/MemtoReg may be don't-care on stores and branches.
                // Gating them with id_valid keeps empty slots clean.
                ex_RegDst   <= id_valid & id_RegDst;
                ex_ALUOp    <= id_ALUOp;
                ex_ALUSrc   <= id_ALUSrc;
                ex_Branch   <= id_Branch;
                ex_MemRead  <= id_MemRead;
                ex_MemWrite <= id_MemWrite;
                ex_RegWrite <= id_RegWrite;
                ex_MemtoReg <= id_valid & id_MemtoReg;
                ex_valid    <= id_valid;
            end

            // Stall cycles are counted even when a flush wins the bubble.
            if (stall && !countSaturated) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_register.sv
module tb_id_ex_register;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_RegDst, id_ALUSrc, id_Branch, id_MemRead, id_MemWrite, id_RegWrite, id_MemtoReg;
    logic [1:0]  id_ALUOp;
    logic        id_valid;
    logic [31:0] id_pc_plus4, id_rdata1, id_rdata2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush;
    logic        ex_RegDst, ex_ALUSrc, ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg;
    logic [1:0]  ex_ALUOp;
    logic        ex_valid;
    logic [31:0] ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        stall;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    id_ex_register dut (
        .clk(clk), .reset(reset),
        .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_Branch(id_Branch),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_RegWrite(id_RegWrite),
        .id_MemtoReg(id_MemtoReg), .id_ALUOp(id_ALUOp), .id_valid(id_valid),
        .id_pc_plus4(id_pc_plus4), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .ex_RegDst(ex_RegDst), .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_RegWrite(ex_RegWrite),
        .ex_MemtoReg(ex_MemtoReg), .ex_valid(ex_valid),
        .ex_pc_plus4(ex_pc_plus4), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .stall(stall), .stall_count(stall_count)
    );

    typedef struct {
        logic        reset, flush, valid;
        logic        RegDst, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg;
        logic [1:0]  ALUOp;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  rs, rt, rd;
    } idIn_t;

    // ctrl = {RegDst, ALUOp[1:0], ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg}
    // regs = {rs, rt, rd}
    typedef struct packed {
        logic [8:0]   ctrl;
        logic         valid;
        logic [127:0] data;
        logic [14:0]  regs;
        logic [15:0]  cnt;
    } exState_t;

    exState_t   model = '0;
    exState_t   stateQ[$];
    logic [1:0] stallQ[$];   // {check enable, expected stall}
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pipeline slot, a load-use rule and a saturating counter.
    function automatic exState_t nextState(input exState_t cur, input idIn_t i, output logic hz);
        exState_t n;
        logic [4:0] loadDst;
        logic       loadInEx;
        loadDst  = cur.regs[9:5];
        loadInEx = cur.valid && cur.ctrl[3];
        hz = loadInEx && i.valid && loadDst != 5'd0 && (loadDst == i.rs || loadDst == i.rt);
        n = '0;
        if (!i.reset) begin
            n.data = {i.pc, i.r1, i.r2, i.imm};
            n.regs = {i.rs, i.rt, i.rd};
            if (!(i.flush || hz)) begin
                n.valid = i.valid;
                n.ctrl  = {i.valid && i.RegDst, i.ALUOp, i.ALUSrc, i.Branch, i.MemRead,
                           i.MemWrite, i.RegWrite, i.valid && i.MemtoReg};
            end
            if (hz && cur.cnt < 16'hFFFF) n.cnt = cur.cnt + 16'd1;
            else                          n.cnt = cur.cnt;
        end
        return n;
    endfunction

    function automatic idIn_t idle();
        idIn_t i;
        i = '{default: '0};
        return i;
    endfunction

    function automatic logic [4:0] pickReg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd8;
            2: return 5'd9;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic idIn_t randIn();
        idIn_t i;
        i.reset    = ($urandom_range(0, 49) == 0);
        i.flush    = ($urandom_range(0, 9) == 0);
        i.valid    = ($urandom_range(0, 9) != 0);
        i.RegDst   = 1'($urandom_range(0, 1));
        i.ALUSrc   = 1'($urandom_range(0, 1));
        i.Branch   = 1'($urandom_range(0, 1));
        i.MemRead  = ($urandom_range(0, 2) == 0);
        i.MemWrite = 1'($urandom_range(0, 1));
        i.RegWrite = 1'($urandom_range(0, 1));
        i.MemtoReg = 1'($urandom_range(0, 1));
        i.ALUOp    = 2'($urandom_range(0, 3));
        i.pc       = $urandom;
        i.r1       = $urandom;
        i.r2       = $urandom;
        i.imm      = $urandom;
        i.rs       = pickReg();
        i.rt       = pickReg();
        i.rd       = pickReg();
        return i;
    endfunction

    // Entered at a falling edge: drive ID, record expectations, wait for the next falling edge.
    task automatic cycle(input idIn_t i, input bit chkStall = 1'b1);
        logic     hz;
        exState_t n;
        reset = i.reset;  flush = i.flush;  id_valid = i.valid;
        id_RegDst = i.RegDst;  id_ALUSrc = i.ALUSrc;  id_Branch = i.Branch;
        id_MemRead = i.MemRead;  id_MemWrite = i.MemWrite;  id_RegWrite = i.RegWrite;
        id_MemtoReg = i.MemtoReg;  id_ALUOp = i.ALUOp;
        id_pc_plus4 = i.pc;  id_rdata1 = i.r1;  id_rdata2 = i.r2;  id_imm = i.imm;
        id_rs = i.rs;  id_rt = i.rt;  id_rd = i.rd;
        n = nextState(model, i, hz);
        stallQ.push_back({chkStall, hz});
        stateQ.push_back(n);
        model = n;
        @(negedge clk);
    endtask

    function automatic idIn_t loadWord(input logic [4:0] rt);
        idIn_t i;
        i = idle();
        i.valid = 1'b1;  i.MemRead = 1'b1;  i.ALUSrc = 1'b1;  i.RegWrite = 1'b1;  i.MemtoReg = 1'b1;
        i.rs = 5'd29;  i.rt = rt;  i.imm = 32'h10;  i.pc = 32'h100;
        return i;
    endfunction

    function automatic idIn_t rType(input logic [4:0] rs, input logic [4:0] rt);
        idIn_t i;
        i = idle();
        i.valid = 1'b1;  i.RegDst = 1'b1;  i.ALUOp = 2'b10;  i.RegWrite = 1'b1;
        i.r1 = 32'h5;  i.r2 = 32'h7;  i.rs = rs;  i.rt = rt;  i.rd = 5'd3;  i.pc = 32'h104;
        return i;
    endfunction

    // Monitor: checks stall mid-cycle and the registered outputs just after each rising edge.
    initial begin
        logic [1:0] s;
        exState_t   e, act;
        forever begin
            @(negedge clk);
            #2;
            if (stallQ.size() > 0) begin
                s = stallQ.pop_front();
                if (s[1]) check("stall", {127'd0, stall}, {127'd0, s[0]});
            end
            @(posedge clk);
            #1;
            if (stateQ.size() > 0) begin
                e   = stateQ.pop_front();
                act.ctrl  = {ex_RegDst, ex_ALUOp, ex_ALUSrc, ex_Branch, ex_MemRead,
                             ex_MemWrite, ex_RegWrite, ex_MemtoReg};
                act.valid = ex_valid;
                act.data  = {ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm};
                act.regs  = {ex_rs, ex_rt, ex_rd};
                act.cnt   = stall_count;
                check("ex_controls",    {119'd0, act.ctrl},  {119'd0, e.ctrl});
                check("ex_valid",       {127'd0, act.valid}, {127'd0, e.valid});
                check("ex_datapath",    act.data,            e.data);
                check("ex_regnums",     {113'd0, act.regs},  {113'd0, e.regs});
                check("stall_count",    {112'd0, act.cnt},   {112'd0, e.cnt});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idIn_t i;
        @(negedge clk);
        i = idle();  i.reset = 1'b1;
        cycle(i, 1'b0);                 // outputs unknown before the first reset edge
        cycle(i);
        cycle(idle());

        // Plain R-type capture
        cycle(rType(5'd1, 5'd2));
        cycle(idle());

        // Load-use hazard: stall once, bubble, then the held add is captured
        cycle(loadWord(5'd8));
        cycle(rType(5'd8, 5'd2));
        cycle(rType(5'd8, 5'd2));
        cycle(idle());

        // Zero register is never a dependency
        cycle(loadWord(5'd0));
        cycle(rType(5'd0, 5'd0));
        cycle(idle());

        // Empty slot gates RegDst/MemtoReg
        i = rType(5'd1, 5'd2);  i.valid = 1'b0;  i.MemtoReg = 1'b1;
        cycle(i);

        // Flush squashes a store; flush together with a hazard still counts a stall
        i = idle();  i.valid = 1'b1;  i.MemWrite = 1'b1;  i.ALUSrc = 1'b1;  i.rs = 5'd4;  i.rt = 5'd5;
        i.flush = 1'b1;
        cycle(i);
        cycle(loadWord(5'd8));
        i = rType(5'd2, 5'd8);  i.flush = 1'b1;
        cycle(i);
        cycle(idle());

        // Reset while stalled clears everything, and stall drops afterwards
        cycle(loadWord(5'd9));
        i = rType(5'd9, 5'd1);  i.reset = 1'b1;
        cycle(i);
        cycle(rType(5'd9, 5'd1));
        cycle(idle());

        // Randomized traffic
        for (int n = 0; n < 600; n++) cycle(randIn());
        cycle(idle());

        // Saturation: load the counter near its limit, then force two hazard cycles
        force dut.stall_count = 16'hFFFE;
        model.cnt = 16'hFFFE;
        cycle(idle());
        release dut.stall_count;
        cycle(loadWord(5'd8));
        cycle(rType(5'd8, 5'd8));
        cycle(loadWord(5'd8));
        cycle(rType(5'd8, 5'd8));
        cycle(idle());
        cycle(idle());

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (stateQ.size() != 0 || stallQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", stateQ.size() + stallQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
